mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width (only 32 is supported).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_val  input  32  multiplicand or dividend.
REQ-007 SHALL have port rt_val  input  32  multiplier or divisor.
REQ-008 SHALL have port busy  output  1  operation in progress; high in CALC and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when hi/lo are valid.
REQ-010 SHALL have port hi  output  32  high result (product[63:32] or remainder).
REQ-011 SHALL have port lo  output  32  low result (product[31:0] or quotient).
REQ-012 SHALL have ports hi_write, lo_write  output  1 each  HI/LO register write strobes.
REQ-013 SHALL have ports hi_select, lo_select  output  2 each  HI/LO source select codes.
REQ-014 SHALL have port div_by_zero  output  1  divide with rt_val==0; valid with done.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 SHALL transition IDLE->CALC when start=1, latching op, rs_val and rt_val at that edge (edge N).
REQ-017 SHALL transition IDLE->DONE at edge N when op is DIV or DIVU and rt_val==0 (no CALC).
REQ-018 SHALL remain in CALC for exactly 32 cycles, one iteration per cycle, using a 6-bit counter.
REQ-019 SHALL transition CALC->DONE after iteration 32 and DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL assert done in the DONE cycle only: cycle N+33 for a normal operation, N+1 for divide-by-zero.
REQ-021 SHALL ignore start outside IDLE, including the DONE cycle; there is no queuing.
REQ-022 SHALL, for signed ops, convert operands to magnitudes, run the unsigned core and apply result signs in DONE.
REQ-023 SHALL compute multiply by iterative shift-add into a 64-bit product; signed product is negated when operand signs differ.
REQ-024 SHALL compute divide by iterative restoring division; lo=quotient, hi=remainder.
REQ-025 SHALL, for DIV, negate the quotient when operand signs differ and give the remainder the sign of the dividend.
REQ-026 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0x00000000 without any error flag.
REQ-027 SHALL, on divide-by-zero, produce lo=0xFFFFFFFF and hi=rs_val, with div_by_zero=1 in the DONE cycle.
REQ-028 SHALL clear div_by_zero in all cycles other than a divide-by-zero DONE cycle.
REQ-029 SHALL, in DONE, set hi_write=lo_write=1, with hi_select=lo_select=11 for multiply and 10 for divide.
REQ-030 SHALL hold hi_write=lo_write=0 and hi_select=lo_select=00 outside DONE.
REQ-031 SHALL hold hi/lo at the last result until the next DONE, and shall not change them during CALC.
REQ-032 SHALL keep operand input changes after edge N from affecting the current result.

Reset
REQ-033 SHALL, while rst=1, immediately force the FSM to IDLE, counter=0, and busy, done, div_by_zero, hi_write, lo_write=0.
REQ-034 SHALL, while rst=1, force hi_select=lo_select=00 and hi=lo=0.
REQ-035 SHALL, on reset during CALC or DONE, abort the operation with no done pulse; the first start after rst deasserts is accepted normally.

Verification
REQ-036 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at N+33: done=1, hi=0xFFFFFFFE, lo=0x00000001, selects=11, writes=1.
REQ-037 SHALL cover: MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0 x anything -> hi=lo=0.
REQ-038 SHALL cover: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; selects=10.
REQ-039 SHALL cover: DIV 0x1234/0 -> done at N+1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 SHALL cover: start re-pulsed during CALC and in the DONE cycle -> ignored; exactly one done; second start after IDLE accepted.
REQ-041 SHALL cover: rst pulsed at CALC cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse; a following MULTU 2x3 gives lo=6.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO write strobes.
// Signed operations run on magnitudes; signs are fixed up as the result is captured.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_write,
  output logic             lo_write,
  output logic [1:0]       hi_select,
  output logic [1:0]       lo_select,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;

  localparam logic [5:0]         LAST_ITER = 6'd31;
  localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t             state_r, state_nx_s;
  logic [5:0]         cnt_r;
  logic               op_div_r, neg_res_r, neg_rem_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r, acc_nx_s;

  logic               is_div_s, is_signed_s, rs_neg_s, rt_neg_s;
  logic               accept_s, dbz_s, last_s;
  logic [1:0]         sel_nx_s;
  logic [WIDTH-1:0]   rs_mag_s, rt_mag_s;
  logic [WIDTH:0]     sum_s, upper_s;
  logic [2*WIDTH:0]   shifted_s;
  logic [WIDTH-1:0]   rem_sub_s, quo_s, rem_s, res_hi_s, res_lo_s;
  logic [2*WIDTH-1:0] prod_s;

  assign is_div_s    = op[1];
  assign is_signed_s = ~op[0];
  assign rs_neg_s    = is_signed_s & rs_val[WIDTH-1];
  assign rt_neg_s    = is_signed_s & rt_val[WIDTH-1];
  assign rs_mag_s    = rs_neg_s ? (~rs_val + ONE_W) : rs_val;
  assign rt_mag_s    = rt_neg_s ? (~rt_val + ONE_W) : rt_val;
  assign accept_s    = (state_r == IDLE) & start;
  assign dbz_s       = accept_s & is_div_s & (rt_val == {WIDTH{1'b0}});
  assign last_s      = (state_r == CALC) & (cnt_r == LAST_ITER);
  assign sel_nx_s    = ((state_r == IDLE) ? is_div_s : op_div_r) ? 2'b10 : 2'b11;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // FSM next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = dbz_s ? DONE : CALC;
        else       state_nx_s = IDLE;
      end
      CALC: begin
        if (cnt_r == LAST_ITER) state_nx_s = DONE;
        else                    state_nx_s = CALC;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // One shift-add or restoring-divide step; acc holds {product} or {remainder, quotient}
  always_comb begin
    sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    shifted_s = {acc_r, 1'b0};
    upper_s   = shifted_s[2*WIDTH:WIDTH];
    rem_sub_s = upper_s[WIDTH-1:0] - opnd_r;
    if (op_div_r) begin
      if (upper_s >= {1'b0, opnd_r}) acc_nx_s = {rem_sub_s, shifted_s[WIDTH-1:1], 1'b1};
      else                           acc_nx_s = {upper_s[WIDTH-1:0], shifted_s[WIDTH-1:0]};
    end else begin
      acc_nx_s = {sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final iteration's result
  always_comb begin
    prod_s = neg_res_r ? (~acc_nx_s + ONE_2W) : acc_nx_s;
    quo_s  = neg_res_r ? (~acc_nx_s[WIDTH-1:0] + ONE_W) : acc_nx_s[WIDTH-1:0];
    rem_s  = neg_rem_r ? (~acc_nx_s[2*WIDTH-1:WIDTH] + ONE_W) : acc_nx_s[2*WIDTH-1:WIDTH];
    if (op_div_r) begin
      res_hi_s = rem_s;
      res_lo_s = quo_s;
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= 6'd0;
      opnd_r    <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
    end else if (accept_s) begin
      op_div_r  <= is_div_s;
      neg_res_r <= rs_neg_s ^ rt_neg_s;
      neg_rem_r <= rs_neg_s & is_div_s;
      cnt_r     <= 6'd0;
      opnd_r    <= is_div_s ? rt_mag_s : rs_mag_s;
      acc_r     <= {{WIDTH{1'b0}}, (is_div_s ? rs_mag_s : rt_mag_s)};
    end else if (state_r == CALC) begin
      acc_r <= acc_nx_s;
      cnt_r <= cnt_r + 6'd1;
    end
  end

  // Registered status, strobes and HI/LO results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hi_write    <= 1'b0;
      lo_write    <= 1'b0;
      hi_select   <= 2'b00;
      lo_select   <= 2'b00;
      div_by_zero <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
    end else begin
      busy        <= (state_nx_s != IDLE);
      done        <= (state_nx_s == DONE);
      hi_write    <= (state_nx_s == DONE);
      lo_write    <= (state_nx_s == DONE);
      hi_select   <= (state_nx_s == DONE) ? sel_nx_s : 2'b00;
      lo_select   <= (state_nx_s == DONE) ? sel_nx_s : 2'b00;
      div_by_zero <= dbz_s;
      if (dbz_s) begin
        hi <= rs_val;
        lo <= {WIDTH{1'b1}};
      end else if (last_s) begin
        hi <= res_hi_s;
        lo <= res_lo_s;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized scoreboard bench for mult_div_unit: the driver queues expected
// results from an arithmetic reference model; a negedge monitor checks every done.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = 32'h0, rt_val = 32'h0;
  logic        busy, done, hi_write, lo_write, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  hi_select, lo_select;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .hi_write(hi_write), .lo_write(lo_write),
    .hi_select(hi_select), .lo_select(lo_select), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic [1:0]  sel;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_hi = 32'h0, last_lo = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, truncating signed division.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b, output logic z);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    res = 64'h0;
    case (o)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) begin z = 1'b1; res = {a, 32'hFFFF_FFFF}; end
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'h0) begin z = 1'b1; res = {a, 32'hFFFF_FFFF}; end
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop and compare on done, otherwise check strobes, held results and lateness
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", {63'h0, done}, 64'h0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("hi", {32'h0, hi}, {32'h0, e.hi});
          chk("lo", {32'h0, lo}, {32'h0, e.lo});
          chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dbz});
          chk("selects", {60'h0, hi_select, lo_select}, {60'h0, e.sel, e.sel});
          chk("writes", {62'h0, hi_write, lo_write}, 64'h3);
          chk("busy_in_done", {63'h0, busy}, 64'h1);
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end else begin
        chk("idle_strobes", {57'h0, hi_write, lo_write, hi_select, lo_select, div_by_zero}, 64'h0);
        chk("hold_hi", {32'h0, hi}, {32'h0, last_hi});
        chk("hold_lo", {32'h0, lo}, {32'h0, last_lo});
        if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
          chk("done_missing", {63'h0, done}, 64'h1);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Drive one request at the next negedge; returns the cycle its done is due
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int due);
    exp_t e;
    logic [63:0] r;
    logic z;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    r = ref_model(o, a, b, z);
    e.due = cyc + 1 + (z ? 0 : 32);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.dbz = z;
    e.sel = o[1] ? 2'b10 : 2'b11;
    sb_q.push_back(e);
    due = e.due;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int d;
    issue(o, a, b, d);
    wait_idle();
  endtask

  initial begin
    int due;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_strobes", {57'h0, hi_write, lo_write, hi_select, lo_select, div_by_zero}, 64'h0);
    rst = 1'b0;

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'b00, 32'hFFFF_FFFD, 32'd5);
    run(2'b00, 32'h0, $urandom);
    run(2'b10, -32'd7, 32'd2);
    run(2'b11, 32'd7, 32'd2);
    run(2'b10, 32'h1234, 32'h0);
    run(2'b11, 32'hCAFE_F00D, 32'h0);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // start pulses inside CALC and in the DONE cycle must be ignored
    issue(2'b01, 32'd1000, 32'd3, due);
    start = 1'b1; op = 2'b10; rs_val = 32'd100; rt_val = 32'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && cyc < due; i++) @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    run(2'b11, 32'd100, 32'd7);

    // reset in the middle of CALC aborts without a done pulse
    issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, due);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    sb_q.delete();
    last_hi = 32'h0;
    last_lo = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    run(2'b01, 32'd2, 32'd3);

    for (int i = 0; i < 150; i++) run(2'($urandom), rnd_opnd(), rnd_opnd());

    repeat (40) @(negedge clk);
    chk("queue_drained", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
